// File: rtl/sfx_pkg.sv
// Sound-effect arbiter shared definitions: SFX ids, sequence lengths,
// note ROM constants, FSM state encoding and priority helpers.
package sfx_pkg;

  localparam logic [1:0] SFX_NONE    = 2'd0;
  localparam logic [1:0] SFX_EAT     = 2'd1;
  localparam logic [1:0] SFX_LEVELUP = 2'd2;
  localparam logic [1:0] SFX_HIT     = 2'd3;

  localparam int unsigned LEN_EAT     = 2;
  localparam int unsigned LEN_LEVELUP = 4;
  localparam int unsigned LEN_HIT     = 3;

  localparam logic [21:0] EAT_N0 = 22'd95557;
  localparam logic [21:0] EAT_N1 = 22'd75843;
  localparam logic [21:0] LVL_N0 = 22'd191113;
  localparam logic [21:0] LVL_N1 = 22'd151687;
  localparam logic [21:0] LVL_N2 = 22'd127553;
  localparam logic [21:0] LVL_N3 = 22'd95557;
  localparam logic [21:0] HIT_N0 = 22'd255102;
  localparam logic [21:0] HIT_N1 = 22'd303370;
  localparam logic [21:0] HIT_N2 = 22'd382219;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Request/pending vectors are {hit, levelup, eat}; bit n belongs to id n+1,
  // so a larger id is always the higher priority.
  function automatic logic [1:0] top_id(input logic [2:0] v);
    if (v[2])      return SFX_HIT;
    else if (v[1]) return SFX_LEVELUP;
    else if (v[0]) return SFX_EAT;
    else           return SFX_NONE;
  endfunction

  function automatic logic [2:0] id_mask(input logic [1:0] id);
    case (id)
      SFX_EAT:     return 3'b001;
      SFX_LEVELUP: return 3'b010;
      SFX_HIT:     return 3'b100;
      default:     return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/sfx_arbiter_if.sv
// Tone-path bundle around the arbiter.
//   bgm_note_div/bgm_enable : soundtrack in
//   sfx_enable, req_*       : SFX control and one-cycle request pulses
//   note_div/enable_sound   : to note_gen
//   sfx_active              : an SFX currently owns the tone path
// master = stimulus side, slave = arbiter side.
interface sfx_arbiter_if;
  logic [21:0] bgm_note_div;
  logic        bgm_enable;
  logic        sfx_enable;
  logic        req_eat;
  logic        req_levelup;
  logic        req_hit;
  logic [21:0] note_div;
  logic        enable_sound;
  logic        sfx_active;

  modport master (
    output bgm_note_div, bgm_enable, sfx_enable, req_eat, req_levelup, req_hit,
    input  note_div, enable_sound, sfx_active
  );

  modport slave (
    input  bgm_note_div, bgm_enable, sfx_enable, req_eat, req_levelup, req_hit,
    output note_div, enable_sound, sfx_active
  );
endinterface

// File: rtl/sfx_rom.sv
// Combinational note ROM.
//   id, idx   : SFX id and note index
//   note_div  : divisor for that note (0 for unused slots)
//   last_flag : idx is the final note of the sequence
module sfx_rom
  import sfx_pkg::*;
(
  input  logic [1:0]  id,
  input  logic [1:0]  idx,
  output logic [21:0] note_div,
  output logic        last_flag
);

  always_comb begin
    note_div  = '0;
    last_flag = 1'b1;
    case (id)
      SFX_EAT: begin
        last_flag = (idx == 2'(LEN_EAT - 1));
        case (idx)
          2'd0:    note_div = EAT_N0;
          2'd1:    note_div = EAT_N1;
          default: note_div = '0;
        endcase
      end
      SFX_LEVELUP: begin
        last_flag = (idx == 2'(LEN_LEVELUP - 1));
        case (idx)
          2'd0:    note_div = LVL_N0;
          2'd1:    note_div = LVL_N1;
          2'd2:    note_div = LVL_N2;
          default: note_div = LVL_N3;
        endcase
      end
      SFX_HIT: begin
        last_flag = (idx == 2'(LEN_HIT - 1));
        case (idx)
          2'd0:    note_div = HIT_N0;
          2'd1:    note_div = HIT_N1;
          2'd2:    note_div = HIT_N2;
          default: note_div = '0;
        endcase
      end
      default: begin
        note_div  = '0;
        last_flag = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sfx_arbiter.sv
// Shares the note_gen tone path between the soundtrack and gameplay SFX.
//   clk, rst_n : system clock, synchronous active-low reset
//   bus        : sfx_arbiter_if.slave (bgm in, SFX control in, tone out)
//
// state | meaning
// IDLE  | soundtrack passed through (one-cycle latency)
// NOTE  | SFX note sounding for NOTE_TICKS cycles
// GAP   | silent GAP_TICKS cycles after a note, divisor held
module sfx_arbiter
  import sfx_pkg::*;
#(
  parameter int unsigned NOTE_TICKS = 5_000_000,
  parameter int unsigned GAP_TICKS  = 500_000,
  parameter int unsigned CNT_W      = 23
) (
  input  logic          clk,
  input  logic          rst_n,
  sfx_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);
  localparam bit               HAS_GAP   = (GAP_TICKS != 0);

  state_t           state;
  logic [1:0]       cur_id;
  logic [1:0]       idx;
  logic             cur_last;
  logic [CNT_W-1:0] tick;
  logic [2:0]       pending;

  logic [2:0]  req_vec, pend_all;
  logic [1:0]  req_top, start_id, rom_id, rom_idx;
  logic [21:0] rom_note;
  logic        rom_last;
  logic        note_end, gap_end, seq_step, go_idle;

  always_comb begin
    req_vec  = bus.sfx_enable ? {bus.req_hit, bus.req_levelup, bus.req_eat} : 3'b000;
    pend_all = pending | req_vec;
    req_top  = top_id(req_vec);
    note_end = (state == NOTE) && (tick == NOTE_LAST);
    gap_end  = (state == GAP) && (tick == GAP_LAST);
    seq_step = gap_end || (note_end && !HAS_GAP);

    // Start a new sequence from idle, on strict-priority preemption, or
    // back-to-back from pending once the current sequence has finished.
    start_id = SFX_NONE;
    if (state == IDLE)             start_id = top_id(pend_all);
    else if (req_top > cur_id)     start_id = req_top;
    else if (seq_step && cur_last) start_id = top_id(pend_all);

    go_idle = !bus.sfx_enable
           || ((state == IDLE) && (start_id == SFX_NONE))
           || (seq_step && cur_last && (start_id == SFX_NONE));

    // The ROM is always addressed with the note that would be loaded next.
    rom_id  = (start_id != SFX_NONE) ? start_id : cur_id;
    rom_idx = (start_id != SFX_NONE) ? 2'd0 : idx + 2'd1;
  end

  sfx_rom u_rom (
    .id        (rom_id),
    .idx       (rom_idx),
    .note_div  (rom_note),
    .last_flag (rom_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      cur_id           <= SFX_NONE;
      idx              <= '0;
      cur_last         <= 1'b0;
      tick             <= '0;
      pending          <= '0;
      bus.note_div     <= '0;
      bus.enable_sound <= 1'b0;
      bus.sfx_active   <= 1'b0;
    end else if (go_idle) begin
      state            <= IDLE;
      cur_id           <= SFX_NONE;
      idx              <= '0;
      cur_last         <= 1'b0;
      tick             <= '0;
      pending          <= '0;
      bus.note_div     <= bus.bgm_note_div;
      bus.enable_sound <= bus.bgm_enable;
      bus.sfx_active   <= 1'b0;
    end else if (start_id != SFX_NONE) begin
      state            <= NOTE;
      cur_id           <= start_id;
      idx              <= '0;
      cur_last         <= rom_last;
      tick             <= '0;
      pending          <= pend_all & ~id_mask(start_id);
      bus.note_div     <= rom_note;
      bus.enable_sound <= 1'b1;
      bus.sfx_active   <= 1'b1;
    end else if (seq_step) begin
      state            <= NOTE;
      idx              <= idx + 2'd1;
      cur_last         <= rom_last;
      tick             <= '0;
      pending          <= pend_all;
      bus.note_div     <= rom_note;
      bus.enable_sound <= 1'b1;
    end else if (note_end) begin
      state            <= GAP;
      tick             <= '0;
      pending          <= pend_all;
      bus.enable_sound <= 1'b0;
    end else begin
      tick             <= tick + CNT_W'(1);
      pending          <= pend_all;
    end
  end

endmodule

// File: tb/tb_sfx_arbiter.sv
// Directed bench for sfx_arbiter with NOTE_TICKS=4, GAP_TICKS=2.
// Cycle c input = value sampled at posedge c; cycle c output = value visible
// after posedge c-1. rst_n is low for the first two posedges of each scenario.
module tb_sfx_arbiter;

  localparam logic [21:0] B = 22'd200000;

  typedef struct {
    int          sc;
    int          cyc;
    logic [21:0] div;
    logic        en;
    logic        act;
  } chk_t;

  typedef struct {
    int          sc;
    int          cyc;
    logic        sfx;
    logic        hit;
    logic        lvl;
    logic        eat;
    logic [21:0] bdiv;
    logic        ben;
  } stim_t;

  chk_t  chk_q[$];
  stim_t stim_q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sfx_arbiter_if bus();

  sfx_arbiter #(
    .NOTE_TICKS (4),
    .GAP_TICKS  (2),
    .CNT_W      (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic add_chk(input int sc, input int c0, input int c1,
                         input logic [21:0] d, input logic e, input logic a);
    for (int c = c0; c <= c1; c++)
      chk_q.push_back('{sc: sc, cyc: c, div: d, en: e, act: a});
  endtask

  task automatic add_stim(input int sc, input int c, input logic sfx,
                          input logic hit, input logic lvl, input logic eat,
                          input logic [21:0] bdiv = B, input logic ben = 1'b1);
    stim_q.push_back('{sc: sc, cyc: c, sfx: sfx, hit: hit, lvl: lvl, eat: eat,
                       bdiv: bdiv, ben: ben});
  endtask

  // One note: 4 cycles sounding, then 2 silent cycles with the divisor held.
  task automatic add_note(input int sc, input int c, input logic [21:0] d);
    add_chk(sc, c, c + 3, d, 1'b1, 1'b1);
    add_chk(sc, c + 4, c + 5, d, 1'b0, 1'b1);
  endtask

  task automatic play_eat(input int sc, input int c);
    add_note(sc, c,     22'd95557);
    add_note(sc, c + 6, 22'd75843);
  endtask

  task automatic play_hit(input int sc, input int c);
    add_note(sc, c,      22'd255102);
    add_note(sc, c + 6,  22'd303370);
    add_note(sc, c + 12, 22'd382219);
  endtask

  task automatic play_lvl(input int sc, input int c);
    add_note(sc, c,      22'd191113);
    add_note(sc, c + 6,  22'd151687);
    add_note(sc, c + 12, 22'd127553);
    add_note(sc, c + 18, 22'd95557);
  endtask

  task automatic run(input int sc, input int last_c);
    logic        sfx;
    logic [21:0] bd;
    logic        be;
    sfx = 1'b1;
    bd  = B;
    be  = 1'b1;
    rst_n            = 1'b0;
    bus.sfx_enable   = 1'b1;
    bus.req_eat      = 1'b0;
    bus.req_levelup  = 1'b0;
    bus.req_hit      = 1'b0;
    bus.bgm_note_div = B;
    bus.bgm_enable   = 1'b1;
    for (int c = 1; c <= last_c; c++) begin
      @(posedge clk);
      @(negedge clk);
      foreach (chk_q[i]) begin
        if (chk_q[i].sc == sc && chk_q[i].cyc == c) begin
          n_vec++;
          if (bus.note_div !== chk_q[i].div || bus.enable_sound !== chk_q[i].en ||
              bus.sfx_active !== chk_q[i].act) begin
            n_bad++;
            $display("FAIL sc%0d cyc%0d: got div=%0d en=%b act=%b, want div=%0d en=%b act=%b",
                     sc, c, bus.note_div, bus.enable_sound, bus.sfx_active,
                     chk_q[i].div, chk_q[i].en, chk_q[i].act);
          end
        end
      end
      rst_n           = (c >= 2);
      bus.req_eat     = 1'b0;
      bus.req_levelup = 1'b0;
      bus.req_hit     = 1'b0;
      foreach (stim_q[i]) begin
        if (stim_q[i].sc == sc && stim_q[i].cyc == c) begin
          sfx             = stim_q[i].sfx;
          bd              = stim_q[i].bdiv;
          be              = stim_q[i].ben;
          bus.req_eat     = stim_q[i].eat;
          bus.req_levelup = stim_q[i].lvl;
          bus.req_hit     = stim_q[i].hit;
        end
      end
      bus.sfx_enable   = sfx;
      bus.bgm_note_div = bd;
      bus.bgm_enable   = be;
    end
  endtask

  initial begin
    // 0: reset then a single eat
    add_chk(0, 1, 2, 22'd0, 1'b0, 1'b0);
    add_chk(0, 3, 10, B, 1'b1, 1'b0);
    add_stim(0, 10, 1'b1, 1'b0, 1'b0, 1'b1);
    play_eat(0, 11);
    add_chk(0, 23, 25, B, 1'b1, 1'b0);

    // 1: hit preempts eat, eat is not replayed
    add_chk(1, 1, 2, 22'd0, 1'b0, 1'b0);
    add_chk(1, 3, 10, B, 1'b1, 1'b0);
    add_stim(1, 10, 1'b1, 1'b0, 1'b0, 1'b1);
    add_stim(1, 12, 1'b1, 1'b1, 1'b0, 1'b0);
    add_chk(1, 11, 12, 22'd95557, 1'b1, 1'b1);
    play_hit(1, 13);
    add_chk(1, 31, 34, B, 1'b1, 1'b0);

    // 2: lower-priority eat waits behind hit, no idle cycle between
    add_stim(2, 10, 1'b1, 1'b1, 1'b0, 1'b0);
    add_stim(2, 12, 1'b1, 1'b0, 1'b0, 1'b1);
    play_hit(2, 11);
    play_eat(2, 29);
    add_chk(2, 41, 42, B, 1'b1, 1'b0);

    // 3: all three requests in the same cycle
    add_stim(3, 10, 1'b1, 1'b1, 1'b1, 1'b1);
    add_chk(3, 3, 10, B, 1'b1, 1'b0);
    play_hit(3, 11);
    play_lvl(3, 29);
    play_eat(3, 53);
    add_chk(3, 65, 66, B, 1'b1, 1'b0);

    // 4: mute aborts levelup, drops pending eat, ignores requests, bgm unaffected
    add_stim(4, 10, 1'b1, 1'b0, 1'b1, 1'b0);
    add_stim(4, 11, 1'b1, 1'b0, 1'b0, 1'b1);
    add_stim(4, 13, 1'b0, 1'b0, 1'b0, 1'b0);
    add_stim(4, 15, 1'b0, 1'b0, 1'b0, 1'b1);
    add_stim(4, 17, 1'b0, 1'b0, 1'b0, 1'b0, 22'd300000, 1'b0);
    add_stim(4, 20, 1'b1, 1'b0, 1'b0, 1'b0, 22'd300000, 1'b0);
    add_chk(4, 11, 13, 22'd191113, 1'b1, 1'b1);
    add_chk(4, 14, 17, B, 1'b1, 1'b0);
    add_chk(4, 18, 26, 22'd300000, 1'b0, 1'b0);

    // 5: bgm changes pass with one cycle latency, held off during an SFX
    add_stim(5, 5, 1'b1, 1'b0, 1'b0, 1'b0, 22'd123456, 1'b0);
    add_stim(5, 10, 1'b1, 1'b0, 1'b0, 1'b1, 22'd123456, 1'b0);
    add_stim(5, 12, 1'b1, 1'b0, 1'b0, 1'b0, 22'd777, 1'b1);
    add_chk(5, 3, 5, B, 1'b1, 1'b0);
    add_chk(5, 6, 10, 22'd123456, 1'b0, 1'b0);
    play_eat(5, 11);
    add_chk(5, 23, 24, 22'd777, 1'b1, 1'b0);

    // 6: repeated eat queues once, duplicates merge
    add_stim(6, 10, 1'b1, 1'b0, 1'b0, 1'b1);
    add_stim(6, 12, 1'b1, 1'b0, 1'b0, 1'b1);
    add_stim(6, 14, 1'b1, 1'b0, 1'b0, 1'b1);
    play_eat(6, 11);
    play_eat(6, 23);
    add_chk(6, 35, 36, B, 1'b1, 1'b0);

    run(0, 25);
    run(1, 34);
    run(2, 42);
    run(3, 66);
    run(4, 26);
    run(5, 24);
    run(6, 36);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
